index_map_decoder: RTL and testbench

- Inverse of the address-to-index-map path: takes a packed value-to-selector-index map (SIZE entries, $clog2(K) bits each) and recovers the base address that produced it.
- Re-emits the K consecutive numbers as a serial valid/ready stream, each paired with its selector index.
- Sits downstream of the map-producing logic, feeding serial consumers.
- Sequential: capture, SIZE-cycle scan, K-beat emit.

---
 rtl/index_map_decoder.sv | 140 ++++++++++++++
 tb/tb_index_map_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/index_map_decoder.sv
// Recovers the base address from a packed value-to-selector-index map, then replays the
// K numbers as a valid/ready stream. Optional check via `define MAP_CONSISTENCY_CHECK_EN.
module index_map_decoder #(
  parameter  int SIZE = 16,
  parameter  int K    = 8,
  localparam int AW   = $clog2(SIZE),
  localparam int IW   = $clog2(K)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE*IW-1:0] in_map,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_num,
  output logic [IW-1:0]    out_idx,
  output logic             out_last,
  output logic [AW-1:0]    base_addr,
  output logic             base_valid,
  output logic             err_none,
  output logic             err_multi,
  output logic             done
`ifdef MAP_CONSISTENCY_CHECK_EN
  ,
  output logic             err_mismatch
`endif
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

  state_t              state;
  logic [SIZE*IW-1:0]  map_q;
  logic [AW-1:0]       v;
  logic [AW-1:0]       base_q;
  logic [IW-1:0]       k;
  logic                found;
  logic                multi;

  logic [AW-1:0]       v_next;
  logic [IW-1:0]       ent_v;
  logic [IW-1:0]       ent_n;
  logic                cand;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    v_next = v + AW'(1);  // wraps SIZE-1 back to entry 0
    ent_v  = map_q[int'(v) * IW +: IW];
    ent_n  = map_q[int'(v_next) * IW +: IW];
    cand   = (ent_v == '0) && (ent_n == IW'(1));
  end

  // Stream outputs are forced to zero outside EMIT so they read 0 right after reset.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == EMIT);
  assign out_idx   = out_valid ? k : '0;
  assign out_num   = out_valid ? base_addr + AW'(k) : '0;
  assign out_last  = out_valid && (k == IW'(K - 1));

  // NOTE: sequential state uses non-blocking assignments only; the captured map is a flat
  // register (not a RAM), so it is cleared by reset along with the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      map_q      <= '0;
      v          <= '0;
      base_q     <= '0;
      k          <= '0;
      found      <= 1'b0;
      multi      <= 1'b0;
      base_addr  <= '0;
      base_valid <= 1'b0;
      err_none   <= 1'b0;
      err_multi  <= 1'b0;
      done       <= 1'b0;
`ifdef MAP_CONSISTENCY_CHECK_EN
      err_mismatch <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            map_q      <= in_map;
            base_valid <= 1'b0;
            err_none   <= 1'b0;
            err_multi  <= 1'b0;
            v          <= '0;
            found      <= 1'b0;
            multi      <= 1'b0;
`ifdef MAP_CONSISTENCY_CHECK_EN
            err_mismatch <= 1'b0;
`endif
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (cand) begin
            if (!found) base_q <= v;
            else        multi  <= 1'b1;
            found <= 1'b1;
          end
          v <= v_next;
          // The final pointer's candidate is folded in here since found/multi lag a cycle.
          if (v == AW'(SIZE - 1)) begin
            if (!found && !cand) begin
              err_none <= 1'b1;
              done     <= 1'b1;
              state    <= IDLE;
            end else if (multi || (found && cand)) begin
              err_multi <= 1'b1;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              base_valid <= 1'b1;
              base_addr  <= found ? base_q : v;
              k          <= '0;
              state      <= EMIT;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
`ifdef MAP_CONSISTENCY_CHECK_EN
            if (map_q[int'(out_num) * IW +: IW] != k) err_mismatch <= 1'b1;
`endif
            if (k == IW'(K - 1)) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              k <= k + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_index_map_decoder.sv
// Directed bench for index_map_decoder: expected beats are queued when a map is sent and
// popped as the DUT transfers them; timing, flags, stalls and mid-emit reset are checked.
module tb_index_map_decoder;
  localparam int SIZE = 16;
  localparam int K    = 8;
  localparam int AW   = 4;
  localparam int IW   = 3;

  typedef struct packed {
    logic [AW-1:0] num;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SIZE*IW-1:0] in_map = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [AW-1:0]     out_num;
  logic [IW-1:0]     out_idx;
  logic              out_last;
  logic [AW-1:0]     base_addr;
  logic              base_valid;
  logic              err_none;
  logic              err_multi;
  logic              done;
`ifdef MAP_CONSISTENCY_CHECK_EN
  logic              err_mismatch;
`endif

  int    vectors = 0;
  int    miscompares = 0;
  beat_t sb[$];

  always #5 clk = ~clk;

  index_map_decoder #(.SIZE(SIZE), .K(K)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_map(in_map),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_num(out_num), .out_idx(out_idx), .out_last(out_last),
    .base_addr(base_addr), .base_valid(base_valid),
    .err_none(err_none), .err_multi(err_multi), .done(done)
`ifdef MAP_CONSISTENCY_CHECK_EN
    , .err_mismatch(err_mismatch)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SIZE*IW-1:0] make_map(input int base);
    logic [SIZE*IW-1:0] m;
    m = '0;
    for (int j = 0; j < K; j++) m[((base + j) % SIZE) * IW +: IW] = IW'(j);
    return m;
  endfunction

  task automatic push_beats(input int base);
    beat_t b;
    for (int j = 0; j < K; j++) begin
      b.num  = AW'((base + j) % SIZE);
      b.idx  = IW'(j);
      b.last = (j == K - 1);
      sb.push_back(b);
    end
  endtask

  task automatic send_map(input logic [SIZE*IW-1:0] m);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_before_accept", in_ready, 1);
    in_map   = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Leaves the bench at the negedge of cycle SIZE+1 after the accept edge.
  task automatic scan_wait();
    repeat (SIZE) @(negedge clk);
    check("scan_in_ready", in_ready, 0);
    check("scan_no_valid", out_valid, 0);
    check("scan_no_done", done, 0);
    @(negedge clk);
  endtask

  task automatic emit_beats(input bit toggle, input int abort_at, output int xfers);
    beat_t exp;
    beat_t held;
    bit    stalled;
    int    cyc;
    stalled = 1'b0;
    cyc     = 0;
    xfers   = 0;
    held    = '0;
    while (sb.size() > 0 && cyc < 200) begin
      if (abort_at >= 0 && xfers == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_done", done, 0);
        sb.delete();
        return;
      end
      out_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      check("beat_valid", out_valid, 1);
      check("done_during_emit", done, 0);
      if (stalled) check("stall_stable", {out_num, out_idx, out_last}, held);
      if (out_ready) begin
        exp = sb.pop_front();
        check("beat", {out_num, out_idx, out_last}, exp);
        xfers++;
        stalled = 1'b0;
      end else begin
        held    = {out_num, out_idx, out_last};
        stalled = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    check("emit_drained", sb.size(), 0);
    check("emit_done_pulse", done, 1);
    check("emit_valid_drop", out_valid, 0);
    out_ready = 1'b0;
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  task automatic decode_ok(input int base, input bit toggle);
    int x;
    push_beats(base);
    send_map(make_map(base));
    scan_wait();
    check("base_valid", base_valid, 1);
    check("base_addr", base_addr, base);
    check("ok_err_none", err_none, 0);
    check("ok_err_multi", err_multi, 0);
    emit_beats(toggle, -1, x);
    check("xfer_count", x, K);
    check("base_held", base_addr, base);
`ifdef MAP_CONSISTENCY_CHECK_EN
    check("no_mismatch", err_mismatch, 0);
`endif
  endtask

  task automatic decode_err(input logic [SIZE*IW-1:0] m, input bit exp_none, input bit exp_multi);
    send_map(m);
    scan_wait();
    check("err_done_pulse", done, 1);
    check("err_none", err_none, exp_none);
    check("err_multi", err_multi, exp_multi);
    check("err_base_valid", base_valid, 0);
    check("err_no_valid", out_valid, 0);
    @(negedge clk);
    check("err_done_one_cycle", done, 0);
    check("err_still_no_valid", out_valid, 0);
    check("err_flags_held", {err_none, err_multi}, {exp_none, exp_multi});
  endtask

  initial begin
    logic [SIZE*IW-1:0] m;
    int x;

    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_flags", {base_valid, err_none, err_multi, done}, 0);
    check("rst_stream", {out_num, out_idx, out_last, base_addr}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    decode_ok(5, 1'b0);
    decode_ok(13, 1'b0);
    decode_err('0, 1'b1, 1'b0);

    m = '0;
    m[3 * IW +: IW]  = IW'(1);
    m[10 * IW +: IW] = IW'(1);
    decode_err(m, 1'b0, 1'b1);

    decode_ok(5, 1'b1);

    push_beats(5);
    send_map(make_map(5));
    scan_wait();
    emit_beats(1'b0, 2, x);
    out_ready = 1'b1;
    @(negedge clk);
    check("in_reset_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_done", done, 0);
    check("post_reset_valid", out_valid, 0);
    check("post_reset_base_valid", base_valid, 0);
    out_ready = 1'b0;
    decode_ok(0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
